// File: rtl/top_level_integration.sv
// rtl/top_level_integration.sv - 32x32 register file with posit<32,2> to IEEE-754 single converter on entry 0
// Optional feature macro: POSIT_ROUND_NEAREST_EVEN_EN (round-to-nearest-even; truncation when undefined).
module top_level_integration (
  input  logic        clk,
  input  logic        reset,
  input  logic        w_en,
  input  logic [4:0]  wa3,
  input  logic [31:0] wd3,
  input  logic [4:0]  ra2,
  output logic [31:0] rd2,
  input  logic        rvalid2,
  output logic        rout2,
  input  logic        proc_done,
  output logic [31:0] final_output,
  output logic        output_valid
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (w_en) begin
      regs[wa3] <= wd3;
    end
  end

  assign rd2 = regs[ra2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rout2 <= 1'b0;
    else        rout2 <= rvalid2;
  end

  // Stage 1: edge-detected start captures the pre-edge value of entry 0.
  logic        pd_q;
  logic        start;
  logic        v1;
  logic [31:0] op_q;

  assign start = proc_done & ~pd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pd_q <= 1'b0;
      v1   <= 1'b0;
      op_q <= '0;
    end else begin
      pd_q <= proc_done;
      v1   <= start;
      if (start) op_q <= regs[0];
    end
  end

  // Regime/exponent/fraction decode of the captured operand.
  logic        d_sign;
  logic        d_zero;
  logic        d_nar;
  logic [30:0] mag;
  logic        r0;
  logic        run;
  logic [4:0]  m;
  logic [5:0]  shamt;
  logic [30:0] tmp;
  logic [7:0]  m4;
  logic [1:0]  e_bits;
  logic [7:0]  d_exp;

  always_comb begin
    d_sign = op_q[31];
    d_zero = (op_q == 32'h0000_0000);
    d_nar  = (op_q == 32'h8000_0000);
    mag    = d_sign ? (~op_q[30:0] + 31'd1) : op_q[30:0];
    r0     = mag[30];
    run    = 1'b1;
    m      = 5'd0;
    for (int i = 30; i >= 0; i--) begin
      if (run && (mag[i] == r0)) m = m + 5'd1;
      else                       run = 1'b0;
    end
    // Skip the regime run plus its terminating bit; the rest is exponent then fraction.
    shamt  = {1'b0, m} + 6'd1;
    tmp    = mag << shamt;
    e_bits = tmp[30:29];
    m4     = {1'b0, m, 2'b00};
    d_exp  = r0 ? (m4 + 8'd123 + {6'd0, e_bits})
                : (8'd127 - m4 + {6'd0, e_bits});
  end

  // Stage 2: decoded fields.
  logic        v2;
  logic        s2_sign;
  logic        s2_zero;
  logic        s2_nar;
  logic [7:0]  s2_exp;
  logic [28:0] s2_frac;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2      <= 1'b0;
      s2_sign <= 1'b0;
      s2_zero <= 1'b0;
      s2_nar  <= 1'b0;
      s2_exp  <= '0;
      s2_frac <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        s2_sign <= d_sign;
        s2_zero <= d_zero;
        s2_nar  <= d_nar;
        s2_exp  <= d_exp;
        s2_frac <= tmp[28:0];
      end
    end
  end

  // Mantissa is s2_frac[28:6]; the low two bits are always zero padding.
  logic        rnd;
  logic        carry;
  logic [22:0] mant;
  logic [7:0]  exp_r;
  logic [31:0] result;

`ifdef POSIT_ROUND_NEAREST_EVEN_EN
  assign rnd = s2_frac[5] & ((|s2_frac[4:0]) | s2_frac[6]);
`else
  logic unused_frac;
  assign rnd         = 1'b0;
  assign unused_frac = ^s2_frac[5:0];
`endif

  assign {carry, mant} = {1'b0, s2_frac[28:6]} + {23'd0, rnd};
  assign exp_r         = s2_exp + {7'd0, carry};
  assign result        = s2_nar  ? 32'h7FC0_0000 :
                         s2_zero ? 32'h0000_0000 :
                                   {s2_sign, exp_r, mant};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      final_output <= '0;
      output_valid <= 1'b0;
    end else begin
      output_valid <= v2;
      if (v2) final_output <= result;
    end
  end

endmodule

// File: tb/tb_top_level_integration.sv
// tb/tb_top_level_integration.sv - scoreboard bench for top_level_integration
module tb_top_level_integration;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        w_en = 1'b0;
  logic [4:0]  wa3 = '0;
  logic [31:0] wd3 = '0;
  logic [4:0]  ra2 = '0;
  logic [31:0] rd2;
  logic        rvalid2 = 1'b0;
  logic        rout2;
  logic        proc_done = 1'b0;
  logic [31:0] final_output;
  logic        output_valid;

  top_level_integration dut (
    .clk(clk), .reset(reset), .w_en(w_en), .wa3(wa3), .wd3(wd3),
    .ra2(ra2), .rd2(rd2), .rvalid2(rvalid2), .rout2(rout2),
    .proc_done(proc_done), .final_output(final_output), .output_valid(output_valid)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          n_valid = 0;
  int          n_pushed = 0;
  int          snap;
  logic [31:0] sb [$];
  logic [31:0] mon_exp;
  logic [31:0] ops  [10];
  logic [31:0] exps [10];

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] v);
    sb.push_back(v);
    n_pushed++;
  endtask

  always @(negedge clk) begin
    if (output_valid === 1'b1) begin
      n_valid++;
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected_valid got=%h exp=no_pending", final_output);
      end
      if (sb.size() > 0) begin
        mon_exp = sb.pop_front();
        checks++;
        assert (final_output === mon_exp) else begin
          errors++;
          $error("FAIL sb_result got=%h exp=%h", final_output, mon_exp);
        end
      end
    end
  end

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    w_en = 1'b1; wa3 = a; wd3 = d;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic convert(input logic [31:0] op, input logic [31:0] exp);
    write_reg(5'd0, op);
    proc_done = 1'b1;
    push_exp(exp);
    @(negedge clk);
    proc_done = 1'b0;
    @(negedge clk);
    check32("lat_e1_valid", {31'd0, output_valid}, 32'd0);
    @(negedge clk);
    check32("lat_e2_valid", {31'd0, output_valid}, 32'd1);
    @(negedge clk);
    check32("lat_e3_valid", {31'd0, output_valid}, 32'd0);
    check32("hold_result", final_output, exp);
  endtask

  initial begin
    ops[0] = 32'h718F_0000; exps[0] = 32'h43E3_C000;
    ops[1] = 32'h7BFF_FEA9; exps[1] = 32'h477F_FF54;
    ops[2] = 32'h7BFF_FEAB;
`ifdef POSIT_ROUND_NEAREST_EVEN_EN
    exps[2] = 32'h477F_FF56;
`else
    exps[2] = 32'h477F_FF55;
`endif
    ops[3] = 32'h4000_0000; exps[3] = 32'h3F80_0000;
    ops[4] = 32'hC000_0000; exps[4] = 32'hBF80_0000;
    ops[5] = 32'h8000_0000; exps[5] = 32'h7FC0_0000;
    ops[6] = 32'h0000_0000; exps[6] = 32'h0000_0000;
    ops[7] = 32'h7FFF_FFFF; exps[7] = 32'h7B80_0000;
    ops[8] = 32'h0000_0001; exps[8] = 32'h0380_0000;
    ops[9] = 32'hFFFF_FFFF; exps[9] = 32'h8380_0000;

    #2 reset = 1'b0;
    #1;
    check32("rst_final_output", final_output, 32'd0);
    check32("rst_output_valid", {31'd0, output_valid}, 32'd0);
    check32("rst_rout2", {31'd0, rout2}, 32'd0);
    check32("rst_rd2", rd2, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    @(negedge clk);
    rvalid2 = 1'b1;
    #1 check32("rout2_delay0", {31'd0, rout2}, 32'd0);
    @(negedge clk);
    check32("rout2_delay1", {31'd0, rout2}, 32'd1);
    rvalid2 = 1'b0;
    @(negedge clk);
    check32("rout2_fall", {31'd0, rout2}, 32'd0);

    write_reg(5'd7, 32'hDEAD_BEEF);
    ra2 = 5'd7;
    #1 check32("rd2_write", rd2, 32'hDEAD_BEEF);
    @(negedge clk);
    w_en = 1'b1; wa3 = 5'd7; wd3 = 32'h1234_5678;
    #1 check32("rd2_preedge", rd2, 32'hDEAD_BEEF);
    @(negedge clk);
    w_en = 1'b0;
    #1 check32("rd2_postedge", rd2, 32'h1234_5678);
    ra2 = 5'd0;

    for (int i = 0; i < 10; i++) convert(ops[i], exps[i]);
    #1 check32("rd2_entry0", rd2, 32'hFFFF_FFFF);

    // Back-to-back starts; second start writes entry 0 on its own edge.
    @(negedge clk);
    w_en = 1'b1; wa3 = 5'd0; wd3 = 32'h4000_0000;
    @(negedge clk);
    w_en = 1'b0; proc_done = 1'b1;
    push_exp(32'h3F80_0000);
    @(negedge clk);
    proc_done = 1'b0; w_en = 1'b1; wd3 = 32'hC000_0000;
    @(negedge clk);
    proc_done = 1'b1; wd3 = 32'h7FFF_FFFF;
    push_exp(32'hBF80_0000);
    snap = n_valid;
    @(negedge clk);
    proc_done = 1'b0; w_en = 1'b0;
    repeat (3) @(negedge clk);
    check32("pipe_pulses", n_valid - snap, 32'd2);
    check32("pipe_entry0", rd2, 32'h7FFF_FFFF);

    write_reg(5'd0, 32'h718F_0000);
    snap = n_valid;
    proc_done = 1'b1;
    push_exp(32'h43E3_C000);
    repeat (5) @(negedge clk);
    proc_done = 1'b0;
    repeat (4) @(negedge clk);
    check32("hold_pulses", n_valid - snap, 32'd1);

    write_reg(5'd0, 32'h4000_0000);
    write_reg(5'd5, 32'h0000_0055);
    rvalid2 = 1'b1;
    ra2 = 5'd0;
    @(negedge clk);
    proc_done = 1'b1;
    @(negedge clk);
    proc_done = 1'b0;
    #1 reset = 1'b0;
    #1;
    check32("midrst_final_output", final_output, 32'd0);
    check32("midrst_output_valid", {31'd0, output_valid}, 32'd0);
    check32("midrst_rout2", {31'd0, rout2}, 32'd0);
    check32("midrst_rd2_e0", rd2, 32'd0);
    ra2 = 5'd5;
    #1 check32("midrst_rd2_e5", rd2, 32'd0);
    rvalid2 = 1'b0;
    snap = n_valid;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check32("midrst_no_valid", n_valid - snap, 32'd0);
    check32("midrst_final_hold", final_output, 32'd0);

    check32("sb_drained", sb.size(), 32'd0);
    check32("sb_count", n_valid, n_pushed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/top_level_integration.md
TOP_LEVEL_INTEGRATION -- requirements
Module: top_level_integration

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-low reset; low clears all state.
REQ-004 w_en  input  1  register-file write enable.
REQ-005 wa3  input  5  write address.
REQ-006 wd3  input  32  write data.
REQ-007 ra2  input  5  read address.
REQ-008 rd2  output  32  read data.
REQ-009 rvalid2  input  1  read-request strobe.
REQ-010 rout2  output  1  read-request acknowledge.
REQ-011 proc_done  input  1  start conversion of register 0.
REQ-012 final_output  output  32  IEEE-754 single-precision result.
REQ-013 output_valid  output  1  one-cycle result-valid pulse.

Function
REQ-014 SHALL contain a 32x32 register file; all 32 entries are writable, including entry 0.
REQ-015 When w_en=1 at a rising clk edge, the file SHALL store wd3 into entry wa3.
REQ-016 rd2 SHALL be the combinational value of entry ra2, showing the pre-edge value on a same-cycle write.
REQ-017 rout2 SHALL equal rvalid2 delayed by one clk.
REQ-018 Rising-edge detect on proc_done: a start SHALL occur only at a clk edge where proc_done=1 and its registered previous value=0.
- A held-high proc_done SHALL start exactly one conversion.
REQ-019 At the start edge, the block SHALL capture entry 0 as an operand; a write to entry 0 on that same edge SHALL NOT affect the captured operand.
REQ-020 Conversion SHALL treat the operand as posit<32,2>:
- 0x00000000 SHALL give 0x00000000.
- 0x80000000 (NaR) SHALL give 0x7FC00000.
- Otherwise, if bit 31 is set, the magnitude SHALL be the two's complement of the operand.
REQ-021 Regime decode:
- Run of m identical bits after the sign, ended by an opposite bit or by bit 0.
- k=m-1 for ones; k=-m for zeros.
- The next 2 bits are the exponent e; missing bits SHALL read as 0.
- The remaining bits are the fraction, left-aligned, up to 27 bits.
REQ-022 Float fields:
- Exponent SHALL be 4k+e+127, always in the range 7..247, so the output is always normal.
- Sign SHALL equal the posit sign.
- Mantissa SHALL be the top 23 fraction bits, processed per REQ-028.
- A mantissa carry-out SHALL increment the exponent.
REQ-023 Latency:
- final_output SHALL be registered.
- The result SHALL appear, with output_valid=1 for exactly one cycle, on the second clk edge after the start edge.
REQ-024 final_output SHALL hold its last result until the next conversion completes.
REQ-025 A new start during an in-flight conversion SHALL be pipelined and complete in order; no result is dropped.

Reset
REQ-026 While reset=0, the block SHALL immediately (asynchronously) force:
- final_output=0, output_valid=0, rout2=0;
- the proc_done edge register and the pipeline valid bits to 0;
- all register-file entries to 0.
REQ-027 An in-flight conversion interrupted by reset SHALL be discarded and SHALL produce no output_valid.

Configuration
REQ-028 Macro POSIT_ROUND_NEAREST_EVEN_EN:
- Defined: the mantissa SHALL be rounded to nearest-even using the guard bit (fraction bit 24 below the MSB) and a sticky OR of all lower bits.
- Undefined: the fraction SHALL be truncated to 23 bits.

Verification
REQ-029 Write 0x718F0000 to entry 0, pulse proc_done -> final_output=0x43E3C000 with output_valid one cycle, two edges later.
REQ-030 Write 0x7BFFFEA9, pulse proc_done -> final_output=0x477FFF54 (both configurations).
REQ-031 Write 0x7BFFFEAB, pulse proc_done -> final_output=0x477FFF56 with macro defined, 0x477FFF55 without.
REQ-032 Convert each operand, one after another:
- 0x40000000 -> 0x3F800000
- 0xC0000000 -> 0xBF800000
- 0x80000000 -> 0x7FC00000
- 0x00000000 -> 0x00000000
- 0x7FFFFFFF -> 0x7B800000
REQ-033 Hold proc_done high for 5 cycles -> exactly one output_valid pulse.
REQ-034 Assert reset low mid-conversion -> no output_valid; final_output=0; rd2 for ra2=0 reads 0.
